semi_switch_pipe: RTL and testbench

- Parametrised, registered successor to the semigraphics source selector in the VDG replacement pixel path.
- Selects one of NUM_SRC semigraphics generators (SG4, SG6, and later SG8/SG12/SG24) and forwards its data byte and colour code downstream.
- Mode changes are deferred to character boundaries, so a character cell is never split between two sources.
- Adds blanking override, source-valid forwarding and a sticky illegal-select flag.

---
 rtl/semi_switch_pipe.sv | 69 ++++++
 tb/tb_semi_switch_pipe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/semi_switch_pipe.sv
// semi_switch_pipe: registered semigraphics source selector with character-aligned switching
module semi_switch_pipe #(
    parameter int DATA_W = 8,
    parameter int COL_W = 4,
    parameter int NUM_SRC = 2,
    parameter int SEL_W = 1,
    parameter logic [COL_W-1:0] BLANK_COL = 4'h0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      CharStrobe,
    input  logic [SEL_W-1:0]          SelReq,
    input  logic [NUM_SRC*DATA_W-1:0] SrcData,
    input  logic [NUM_SRC*COL_W-1:0]  SrcColour,
    input  logic [NUM_SRC-1:0]        SrcValid,
    input  logic                      Blank,
    output logic [DATA_W-1:0]         SData,
    output logic [COL_W-1:0]          SColour,
    output logic                      SValid,
    output logic [SEL_W-1:0]          ActiveSel,
    output logic                      SelPending,
    output logic                      SelErr
);
    localparam logic [31:0] NSRC = 32'(NUM_SRC);
    logic [SEL_W-1:0] req_sel, req_nxt, act_nxt;
    logic req_ok;
    logic [DATA_W-1:0] src_d;
    logic [COL_W-1:0] src_c;
    logic src_v;
    // next requested and active source; an in-range request on a strobe cycle commits at once
    always_comb begin
        req_ok = 32'(SelReq) < NSRC;
        req_nxt = req_ok ? SelReq : req_sel;
        act_nxt = CharStrobe ? req_nxt : ActiveSel;
    end
    // source mux; unmatched select values fall back to source 0
    always_comb begin
        src_d = SrcData[0 +: DATA_W];
        src_c = SrcColour[0 +: COL_W];
        src_v = SrcValid[0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (ActiveSel == SEL_W'(i)) begin
                src_d = SrcData[i*DATA_W +: DATA_W];
                src_c = SrcColour[i*COL_W +: COL_W];
                src_v = SrcValid[i];
            end
        end
    end
    // selection state and registered datapath, blank overriding the selected source
    always_ff @(posedge Clk) begin
        if (Reset) begin
            SData <= '0;
            SColour <= BLANK_COL;
            SValid <= 1'b0;
            ActiveSel <= '0;
            req_sel <= '0;
            SelPending <= 1'b0;
            SelErr <= 1'b0;
        end else begin
            SData <= Blank ? '0 : src_d;
            SColour <= Blank ? BLANK_COL : src_c;
            SValid <= Blank ? 1'b0 : src_v;
            ActiveSel <= act_nxt;
            req_sel <= req_nxt;
            SelPending <= req_nxt != act_nxt;
            SelErr <= SelErr | ~req_ok;
        end
    end
endmodule

// File: tb/tb_semi_switch_pipe.sv
// tb_semi_switch_pipe: randomized and directed check of semi_switch_pipe against a cycle reference model
module tb_semi_switch_pipe;
    localparam int DW = 8;
    localparam int CW = 4;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int DB = NS * DW;
    localparam int CB = NS * CW;
    localparam logic [CW-1:0] BC = 4'hC;

    logic Clk = 1'b0;
    logic Reset, CharStrobe, Blank;
    logic [SW-1:0] SelReq;
    logic [DB-1:0] SrcData;
    logic [CB-1:0] SrcColour;
    logic [NS-1:0] SrcValid;
    logic [DW-1:0] SData;
    logic [CW-1:0] SColour;
    logic SValid;
    logic [SW-1:0] ActiveSel;
    logic SelPending, SelErr;

    int n_cmp = 0;
    int n_bad = 0;
    int m_req, m_act, m_pend, m_err, m_d, m_c, m_v;

    semi_switch_pipe #(
        .DATA_W(DW), .COL_W(CW), .NUM_SRC(NS), .SEL_W(SW), .BLANK_COL(BC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .CharStrobe(CharStrobe), .SelReq(SelReq),
        .SrcData(SrcData), .SrcColour(SrcColour), .SrcValid(SrcValid), .Blank(Blank),
        .SData(SData), .SColour(SColour), .SValid(SValid), .ActiveSel(ActiveSel),
        .SelPending(SelPending), .SelErr(SelErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one clock: advance the reference model on the inputs seen at the edge, then compare every output
    task automatic step();
        @(posedge Clk);
        if (Reset) begin
            m_d = 0; m_c = BC; m_v = 0;
            m_act = 0; m_req = 0; m_pend = 0; m_err = 0;
        end else begin
            m_d = Blank ? 0 : int'(SrcData[m_act*DW +: DW]);
            m_c = Blank ? int'(BC) : int'(SrcColour[m_act*CW +: CW]);
            m_v = Blank ? 0 : int'(SrcValid[m_act]);
            if (int'(SelReq) < NS) m_req = int'(SelReq);
            else m_err = 1;
            if (CharStrobe) m_act = m_req;
            m_pend = (m_req != m_act) ? 1 : 0;
        end
        #1;
        chk("sdata", int'(SData), m_d);
        chk("scolour", int'(SColour), m_c);
        chk("svalid", int'(SValid), m_v);
        chk("activesel", int'(ActiveSel), m_act);
        chk("selpending", int'(SelPending), m_pend);
        chk("selerr", int'(SelErr), m_err);
    endtask

    task automatic rand_src();
        SrcData = DB'({$urandom, $urandom});
        SrcColour = CB'($urandom);
        SrcValid = NS'($urandom);
    endtask

    initial begin
        Reset = 1'b1; CharStrobe = 1'b0; Blank = 1'b0; SelReq = '0;
        SrcData = '0; SrcColour = '0; SrcValid = '0;
        m_req = 0; m_act = 0; m_pend = 0; m_err = 0; m_d = 0; m_c = 0; m_v = 0;
        for (int i = 0; i < 2; i++) begin
            rand_src();
            CharStrobe = 1'($urandom); Blank = 1'($urandom); SelReq = SW'($urandom);
            step();
        end
        chk("rst_sdata", int'(SData), 0);
        chk("rst_scolour", int'(SColour), int'(BC));
        chk("rst_activesel", int'(ActiveSel), 0);
        Reset = 1'b0; CharStrobe = 1'b0; Blank = 1'b0; SelReq = 2'd0;
        SrcData = {8'h33, 8'h5A, 8'hA5};
        SrcColour = {4'h7, 4'h9, 4'h3};
        SrcValid = 3'b111;
        step();
        chk("pass_sdata", int'(SData), 8'hA5);
        chk("pass_scolour", int'(SColour), 4'h3);
        SelReq = 2'd1;
        step();
        chk("defer_pending", int'(SelPending), 1);
        for (int i = 0; i < 3; i++) step();
        chk("defer_hold_act", int'(ActiveSel), 0);
        CharStrobe = 1'b1;
        step();
        chk("defer_commit_act", int'(ActiveSel), 1);
        chk("defer_commit_pend", int'(SelPending), 0);
        chk("defer_last_pixel", int'(SData), 8'hA5);
        CharStrobe = 1'b0;
        step();
        chk("defer_new_src", int'(SData), 8'h5A);
        SelReq = 2'd2; CharStrobe = 1'b1;
        step();
        chk("simul_act", int'(ActiveSel), 2);
        chk("simul_pend", int'(SelPending), 0);
        SelReq = 2'd1;
        step();
        SelReq = 2'd3;
        step();
        chk("illegal_err", int'(SelErr), 1);
        chk("illegal_act", int'(ActiveSel), 1);
        SelReq = 2'd0; CharStrobe = 1'b0;
        step();
        chk("illegal_sticky", int'(SelErr), 1);
        Blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CharStrobe = (i == 2);
            step();
            chk("blank_colour", int'(SColour), int'(BC));
        end
        Blank = 1'b0; CharStrobe = 1'b0;
        step();
        chk("blank_commit_act", int'(ActiveSel), 0);
        SelReq = 2'd2;
        step();
        chk("midrst_pending", int'(SelPending), 1);
        Reset = 1'b1;
        step();
        chk("midrst_act", int'(ActiveSel), 0);
        chk("midrst_err_clear", int'(SelErr), 0);
        Reset = 1'b0; SelReq = 2'd3; CharStrobe = 1'b1;
        step();
        chk("midrst_req_lost", int'(ActiveSel), 0);
        CharStrobe = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rand_src();
            Reset = ($urandom_range(63) == 0);
            CharStrobe = ($urandom_range(3) == 0);
            Blank = ($urandom_range(7) == 0);
            SelReq = SW'($urandom);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
